pec_ncpc_rrsched: RTL
=====================

# pec_ncpc_rrsched

Registered round-robin scheduler between the four NCP receive ports and the PEC NCP receive FIFO. Each cycle it picks one valid, enabled port in fair rotating order and acknowledges it. It tags the record with a 4-bit port ID and holds it in a single output stage until the FIFO accepts it. It also keeps a saturating per-port accepted-packet counter for software statistics.

## Interface
- PDW, 256, packet data width.
- PIDW, 16, packet ID width.
- REC (local), 6+32+32+PIDW+4+PDW, output record width.
- iClk  in  1  clock, rising edge.
- iRstn  in  1  reset, asynchronous, active-low.
- iPortEn  in  4  per-port enable; a disabled port is never granted.
- iCntClr  in  1  synchronous clear of all grant counters.
- iReqVld  in  4  per-port request valid; bit i belongs to port i.
- iReqTypeN (N=0..3)  in  6  packet type.
- iReqSrcIPN  in  32  source IP.
- iReqTargIPN  in  32  target IP.
- iReqPktIDN  in  PIDW  packet ID.
- iReqDataN  in  PDW  packet data.
- oReqAck  out  4  one-hot accept pulse; the port's record is taken this cycle.
- oWe  out  1  FIFO write strobe.
- oWData  out  REC  record {type, srcIP, targIP, pktID, portID[3:0], data}.
- iFull  in  1  FIFO full.
- oGrantCnt0..3  out  16  accepted-packet count per port, saturating.

## Operation
- Eligible set: E = iReqVld & iPortEn.
- Output stage: flag vld_q plus the record register rec_q.
- oWe = vld_q & ~iFull.
- free = ~vld_q | ~iFull. The stage is free when it is empty or is draining this cycle, which gives full throughput.
- Grant rule: if free and E≠0, grant the first set bit of E found by searching upward from pointer ptr (2 bits), wrapping 3→0.
- oReqAck has exactly that bit set. It is combinational from iReqVld, iPortEn, ptr, vld_q and iFull. oReqAck is all-zero when there is no grant.
- On a grant to port g:
  - rec_q ← {iReqTypeg, iReqSrcIPg, iReqTargIPg, iReqPktIDg, 4'(g), iReqDatag}.
  - vld_q ← 1.
  - ptr ← (g+1) mod 4.
- With no grant: if oWe is high, vld_q ← 0. Otherwise vld_q and rec_q hold. ptr holds.
- Requesters must keep their valid and fields stable until acked. A port that drops its valid without an ack is simply skipped.
- Counters:
  - oGrantCntg increments on each ack to port g.
  - Counters saturate at 16'hFFFF.
  - iCntClr sets all counters to 0. If iCntClr and an ack occur in the same cycle, clear wins and the counter reads 0.
- Changing iPortEn takes effect on the same cycle's grant. It never affects a record already held in rec_q.

## Timing
- Reset values:
  - vld_q=0, rec_q=0, ptr=0.
  - oWe=0, oWData=0, oReqAck=0.
  - All oGrantCnt=0.
- Reset is asynchronous. Asserting iRstn mid-operation drops any held record without writing it, and returns ptr to 0.
- Latency: an ack in cycle N gives oWe=1 in cycle N+1 if iFull=0.
- Back-to-back: with iFull=0 and continuous requests, one ack and one write occur every cycle.
- Full: while vld_q=1 and iFull=1, there is no ack and oWe=0. oWData stays stable.
  - When iFull falls in cycle M: oWe=1 in M, and a new ack may occur in M.
- Empty stage with iFull=1: one grant is still taken, because vld_q=0 makes the stage free. The scheduler then stalls.
- All four ports valid continuously from reset: grant order is 0,1,2,3,0,…

## Test plan
- Single port: iReqVld=4'b0100 with PktID=16'h00A5 at cycle 2.
  - Required: oReqAck=4'b0100 in cycle 2, oWe=1 in cycle 3, oWData portID field=4'h2, PktID=16'h00A5, oGrantCnt2=1.
- Fairness: all ports valid for 8 cycles, iFull=0.
  - Required: ack order 0,1,2,3,0,1,2,3; each counter reaches 2.
  - Also: ports 1 and 3 valid with ptr=2 → port 3 granted first.
- Backpressure:
  - iFull=1 from reset with port 0 valid. Required: one ack, then no ack; vld_q held and oWe=0 for 5 cycles.
  - iFull released. Required: oWe=1 the same cycle, and the next ack the same cycle.
- Mask: iPortEn=4'b1110 with all ports valid.
  - Required: port 0 is never acked; rotation runs 1,2,3.
  - Required: enabling port 0 mid-stream makes it eligible on the next grant.
- Counters: drive 65537 acks to port 1.
  - Required: oGrantCnt1=16'hFFFF.
  - iCntClr together with an ack. Required: oGrantCnt1=0.
- Reset mid-operation: assert iRstn low while vld_q=1 and iFull=1.
  - Required: oWe=0 and all outputs at reset values immediately.
  - After release, the first grant goes to the lowest valid port, searching from 0.

Source files
------------

// File: rtl/pec_ncpc_rrsched.sv
// Round-robin scheduler from four NCP receive ports into the PEC NCP
// receive FIFO, with one registered output stage and saturating per-port
// grant counters.
// Ports:
//   iClk, iRstn            clock, async active-low reset
//   iPortEn, iCntClr       per-port enable, counter clear
//   iReqVld, iReqType/SrcIP/TargIP/PktID/Data 0..3   per-port requests
//   oReqAck                one-hot accept pulse (combinational)
//   oWe, oWData, iFull     FIFO write side
//   oGrantCnt0..3          accepted-packet counters
module pec_ncpc_rrsched #(
    parameter int PDW  = 256,
    parameter int PIDW = 16,
    localparam int REC = 6 + 32 + 32 + PIDW + 4 + PDW
) (
    input  logic            iClk,
    input  logic            iRstn,
    input  logic [3:0]      iPortEn,
    input  logic            iCntClr,
    input  logic [3:0]      iReqVld,
    input  logic [5:0]      iReqType0,
    input  logic [5:0]      iReqType1,
    input  logic [5:0]      iReqType2,
    input  logic [5:0]      iReqType3,
    input  logic [31:0]     iReqSrcIP0,
    input  logic [31:0]     iReqSrcIP1,
    input  logic [31:0]     iReqSrcIP2,
    input  logic [31:0]     iReqSrcIP3,
    input  logic [31:0]     iReqTargIP0,
    input  logic [31:0]     iReqTargIP1,
    input  logic [31:0]     iReqTargIP2,
    input  logic [31:0]     iReqTargIP3,
    input  logic [PIDW-1:0] iReqPktID0,
    input  logic [PIDW-1:0] iReqPktID1,
    input  logic [PIDW-1:0] iReqPktID2,
    input  logic [PIDW-1:0] iReqPktID3,
    input  logic [PDW-1:0]  iReqData0,
    input  logic [PDW-1:0]  iReqData1,
    input  logic [PDW-1:0]  iReqData2,
    input  logic [PDW-1:0]  iReqData3,
    output logic [3:0]      oReqAck,
    output logic            oWe,
    output logic [REC-1:0]  oWData,
    input  logic            iFull,
    output logic [15:0]     oGrantCnt0,
    output logic [15:0]     oGrantCnt1,
    output logic [15:0]     oGrantCnt2,
    output logic [15:0]     oGrantCnt3
);

    logic           vld_q, vld_d;
    logic [REC-1:0] rec_q, rec_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [15:0]    cnt_q [4];
    logic [15:0]    cnt_d [4];

    logic [3:0] elig;
    logic       free;
    logic       found;
    logic       gnt;
    logic [1:0] gidx;
    logic [1:0] idx;

    assign elig = iReqVld & iPortEn;
    assign oWe  = vld_q & ~iFull;
    // Draining this cycle counts as free so a new record can follow directly.
    assign free = ~vld_q | ~iFull;

    // Rotating search upward from ptr_q, wrapping 3 -> 0.
    always_comb begin
        found = 1'b0;
        gidx  = 2'd0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    // Gating with iRstn keeps oReqAck at zero while reset is held.
    assign gnt     = free & found & iRstn;
    assign oReqAck = gnt ? (4'b0001 << gidx) : 4'b0000;

    always_comb begin
        rec_d = rec_q;
        vld_d = vld_q;
        ptr_d = ptr_q;
        if (gnt) begin
            unique case (gidx)
                2'd0: rec_d = {iReqType0, iReqSrcIP0, iReqTargIP0,
                               iReqPktID0, 4'd0, iReqData0};
                2'd1: rec_d = {iReqType1, iReqSrcIP1, iReqTargIP1,
                               iReqPktID1, 4'd1, iReqData1};
                2'd2: rec_d = {iReqType2, iReqSrcIP2, iReqTargIP2,
                               iReqPktID2, 4'd2, iReqData2};
                2'd3: rec_d = {iReqType3, iReqSrcIP3, iReqTargIP3,
                               iReqPktID3, 4'd3, iReqData3};
            endcase
            vld_d = 1'b1;
            ptr_d = gidx + 2'd1;
        end else if (oWe) begin
            vld_d = 1'b0;
        end
    end

    // Clear takes priority over a same-cycle ack.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            cnt_d[g] = cnt_q[g];
            if (iCntClr) begin
                cnt_d[g] = 16'd0;
            end else if (oReqAck[g] && cnt_q[g] != 16'hFFFF) begin
                cnt_d[g] = cnt_q[g] + 16'd1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            vld_q <= 1'b0;
            rec_q <= '0;
            ptr_q <= 2'd0;
            for (int g = 0; g < 4; g++) begin
                cnt_q[g] <= 16'd0;
            end
        end else begin
            vld_q <= vld_d;
            rec_q <= rec_d;
            ptr_q <= ptr_d;
            for (int g = 0; g < 4; g++) begin
                cnt_q[g] <= cnt_d[g];
            end
        end
    end

    assign oWData     = rec_q;
    assign oGrantCnt0 = cnt_q[0];
    assign oGrantCnt1 = cnt_q[1];
    assign oGrantCnt2 = cnt_q[2];
    assign oGrantCnt3 = cnt_q[3];

endmodule
